// File: rtl/pipeline_seq_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encoding, pipeline shape constants and the NOP instruction word.
package pipeline_seq_pkg;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STALL  = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HDRAIN = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam int          NUM_STAGES = 5;
  localparam int          DATA_W     = 16;
  localparam logic [15:0] NOP_INSTR  = 16'h0000;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with enable, synchronous clear and async active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 count <= '0;
    else if (clr)               count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline. Optional performance
// counters are built when PIPELINE_SEQ_PERF_CNT_EN is defined.
module pipeline_sequencer
  import pipeline_seq_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int HALT_DRAIN   = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_hazard,
  input  logic             control_hazard,
  input  logic             branch_taken,
  input  logic             halt_id,
  output logic             pc_write_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam logic [1:0] DRAIN_LD = 2'(DRAIN_CYCLES - 1);
  localparam logic [1:0] HALT_LD  = 2'(HALT_DRAIN - 1);

  logic [2:0] state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write_en  = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    halted       = 1'b0;
    case (state)
      // INIT covers the release cycle plus one full cycle, so fetch starts in cycle 2
      ST_INIT: begin
        if (cnt == 2'd0) cnt_nxt = 2'd1;
        else begin
          cnt_nxt   = 2'd0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN, ST_STALL: begin
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (branch_taken) begin
          pc_write_en  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_nxt    = ST_RUN;
        end else if (control_hazard && state == ST_RUN) begin
          if_id_en  = 1'b1;
          cnt_nxt   = DRAIN_LD;
          state_nxt = ST_DRAIN;
        end else if (data_hazard) begin
          id_ex_bubble = 1'b1;
          state_nxt    = ST_STALL;
        end else if (halt_id && state == ST_RUN) begin
          if_id_flush = 1'b1;
          cnt_nxt     = HALT_LD;
          state_nxt   = ST_HDRAIN;
        end else begin
          pc_write_en = 1'b1;
          if_id_en    = 1'b1;
          state_nxt   = ST_RUN;
        end
      end
      // only bubbles sit in ID here, so data_hazard is irrelevant
      ST_DRAIN: begin
        id_ex_bubble = 1'b0;
        if (cnt != 2'd0) cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd0 && !control_hazard) state_nxt = ST_RUN;
      end
      ST_HDRAIN: begin
        if (cnt != 2'd0) cnt_nxt = cnt - 2'd1;
        else             state_nxt = ST_HALT;
      end
      ST_HALT: halted = 1'b1;
      default: state_nxt = ST_INIT;
    endcase
  end

`ifdef PIPELINE_SEQ_PERF_CNT_EN
  logic cnt_active;
  assign cnt_active = (state != ST_INIT) && (state != ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (cnt_active && !pc_write_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (cnt_active && if_id_flush),
    .count (flush_cycles)
  );
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed + randomized bench for pipeline_sequencer against a cycle-count
// reference model; counters are checked when PIPELINE_SEQ_PERF_CNT_EN is set.
module tb_pipeline_sequencer;

  localparam int CNT_W  = 16;
  localparam int DRAIN  = 3;
  localparam int HDRAIN = 3;

  localparam int M_INIT = 0, M_RUN = 1, M_HOLD = 2, M_WAIT = 3, M_HLTD = 4, M_STOP = 5;

  logic clk, rst_n;
  logic data_hazard, control_hazard, branch_taken, halt_id;
  logic pc_write_en, if_id_en, if_id_flush, id_ex_bubble, halted;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;
  logic [4:0] outs;

  int total, passed;
  int mode, since_rel, left, stop_cycles;
  int m_stall, m_flush;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .HALT_DRAIN(HDRAIN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_hazard    (data_hazard),
    .control_hazard (control_hazard),
    .branch_taken   (branch_taken),
    .halt_id        (halt_id),
    .pc_write_en    (pc_write_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .halted         (halted),
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
  );

  assign outs = {pc_write_en, if_id_en, if_id_flush, id_ex_bubble, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write_en, if_id_en, if_id_flush, id_ex_bubble, halted}
  function automatic logic [4:0] expect_out(input logic bt, ch, dh, hi);
    case (mode)
      M_RUN:  return bt ? 5'b10110 : ch ? 5'b01000 : dh ? 5'b00010 : hi ? 5'b00100 : 5'b11000;
      M_HOLD: return bt ? 5'b10110 : dh ? 5'b00010 : 5'b11000;
      M_WAIT: return 5'b00100;
      M_HLTD: return 5'b00110;
      M_STOP: return 5'b00111;
      default: return 5'b00110;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
`ifdef PIPELINE_SEQ_PERF_CNT_EN
    return CNT_W'(v);
`else
    return CNT_W'(v * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mode = M_INIT; since_rel = 0; left = 0; stop_cycles = 0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic advance(input logic bt, ch, dh, hi);
    logic [4:0] o;
    o = expect_out(bt, ch, dh, hi);
    if (mode != M_INIT && mode != M_STOP) begin
      if (!o[4] && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (o[2]  && m_flush < (1 << CNT_W) - 1) m_flush++;
    end
    case (mode)
      M_INIT: begin since_rel++; if (since_rel >= 2) mode = M_RUN; end
      M_RUN: begin
        if (bt)      mode = M_RUN;
        else if (ch) begin mode = M_WAIT; left = DRAIN; end
        else if (dh) mode = M_HOLD;
        else if (hi) begin mode = M_HLTD; left = HDRAIN; end
      end
      M_HOLD: mode = (!bt && dh) ? M_HOLD : M_RUN;
      M_WAIT: begin
        if (left > 0) left--;
        if (left == 0 && !ch) mode = M_RUN;
      end
      M_HLTD: begin left--; if (left == 0) mode = M_STOP; end
      M_STOP: stop_cycles++;
      default: mode = M_INIT;
    endcase
  endtask

  // called at a negedge; checks mid-cycle, advances the model at the posedge
  task automatic step(input logic bt, ch, dh, hi);
    branch_taken = bt; control_hazard = ch; data_hazard = dh; halt_id = hi;
    #1;
    chk("outputs", CNT_W'(outs), CNT_W'(expect_out(bt, ch, dh, hi)));
    chk("stall_cycles", stall_cycles, exp_cnt(m_stall));
    chk("flush_cycles", flush_cycles, exp_cnt(m_flush));
    @(posedge clk);
    advance(bt, ch, dh, hi);
    @(negedge clk);
  endtask

  // asynchronous mid-cycle reset, then release at the following negedge
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_outputs"}, CNT_W'(outs), CNT_W'(5'b00110));
    chk({tag, "_stall"}, stall_cycles, '0);
    chk({tag, "_flush"}, flush_cycles, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0;
    data_hazard = 0; control_hazard = 0; branch_taken = 0; halt_id = 0;
    model_reset();
    #1;
    chk("reset_outputs", CNT_W'(outs), CNT_W'(5'b00110));
    chk("reset_stall", stall_cycles, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // release: cycles 0-1 INIT, cycle 2 fetches
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("first_fetch_pc", CNT_W'(pc_write_en), CNT_W'(1));

    // data hazard held two cycles
    step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("stall_after_2", stall_cycles, exp_cnt(2));

    // control hazard pulse, then held five cycles
    step(0, 1, 0, 0); repeat (4) step(0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0); repeat (3) step(0, 0, 0, 0);

    // branch beats data hazard
    step(1, 0, 1, 0); step(0, 0, 0, 0);

    // async reset in the first DRAIN cycle, then INIT repeats
    step(0, 1, 0, 0);
    do_reset("rst_drain");
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);

    // halt drain, branch ignored afterwards, reset clears halted
    step(0, 0, 0, 1); repeat (3) step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    chk("halted_sticky", CNT_W'(halted), CNT_W'(1));
    do_reset("rst_halt");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (stop_cycles > 3 || $urandom_range(79) == 0) do_reset("rst_rand");
      step($urandom_range(7) == 0, $urandom_range(9) == 0,
           $urandom_range(4) == 0, $urandom_range(29) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
